// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the registered N-channel scanning multiplexer.
package mux_scan_n_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    // Prescaler counter width: ceil(log2(div)), never less than one bit.
    function automatic int cnt_width(input int div);
        int w;
        w = 1;
        while ((1 << w) < div) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Data/select/status bundle between the switch inputs and the display datapath.
interface mux_scan_n_if #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic [N*W-1:0] d;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           en;
    logic [W-1:0]   z;
    logic [SW-1:0]  ch;
    logic           tick;

    modport master (
        output d, sel, mode, en,
        input  z, ch, tick
    );

    modport slave (
        input  d, sel, mode, en,
        output z, ch, tick
    );
endinterface

// File: rtl/mux_scan_n_scan_prescaler.sv
// Counts enabled cycles while scanning and flags the last cycle of each channel slot.
module scan_prescaler
    import mux_scan_n_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic run,
    output logic step
);
    localparam int            CW      = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Step on the terminal count; restart the slot when leaving scan or after a step.
    always_comb begin
        step  = en && run && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (en) begin
            if (!run || step) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mux_scan_n.sv
// Registered N-way multiplexer with manual select and auto-scan modes.
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int W   = 4,
    parameter int N   = 4,
    parameter int SW  = 2,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         clr,
    mux_scan_n_if.slave  bus
);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [SW-1:0] ch_q, ch_d;
    logic [W-1:0]  z_q, z_d;
    logic          tick_q, tick_d;
    logic [SW-1:0] selc;
    logic [SW-1:0] ch_nxt;
    logic          step;

    scan_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .clr  (clr),
        .en   (bus.en),
        .run  (bus.mode == MODE_AUTO),
        .step (step)
    );

    // Pick the next channel, then load z from that same channel so z and ch always agree.
    always_comb begin
        selc   = (bus.sel > LAST) ? LAST : bus.sel;
        ch_nxt = (ch_q == LAST) ? '0 : ch_q + SW'(1);
        ch_d   = ch_q;
        z_d    = z_q;
        tick_d = 1'b0;
        if (bus.en) begin
            if (bus.mode == MODE_MANUAL) begin
                ch_d = selc;
            end else if (step) begin
                ch_d   = ch_nxt;
                tick_d = 1'b1;
            end
            z_d = bus.d[int'(ch_d) * W +: W];
        end
    end

    // Output registers with synchronous clear dominating enable and mode.
    always_ff @(posedge clk) begin
        if (clr) begin
            ch_q   <= '0;
            z_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            z_q    <= z_d;
            tick_q <= tick_d;
        end
    end

    assign bus.z    = z_q;
    assign bus.ch   = ch_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: three builds (N=4/DIV=4, N=3/DIV=4, N=4/DIV=1) driven in parallel
// and compared every cycle against a behavioural model, plus directed spot checks.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        clr_tb;
    logic [15:0] d_tb;
    logic [1:0]  sel_tb;
    logic        mode_tb;
    logic        en_tb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_scan_n_if #(.W(4), .N(4), .SW(2)) bus4 ();
    mux_scan_n_if #(.W(4), .N(3), .SW(2)) bus3 ();
    mux_scan_n_if #(.W(4), .N(4), .SW(2)) bus1 ();

    assign bus4.d = d_tb;          assign bus3.d = d_tb[11:0];    assign bus1.d = d_tb;
    assign bus4.sel = sel_tb;      assign bus3.sel = sel_tb;      assign bus1.sel = sel_tb;
    assign bus4.mode = mode_tb;    assign bus3.mode = mode_tb;    assign bus1.mode = mode_tb;
    assign bus4.en = en_tb;        assign bus3.en = en_tb;        assign bus1.en = en_tb;

    mux_scan_n #(.W(4), .N(4), .SW(2), .DIV(4)) dut4 (.clk(clk), .clr(clr_tb), .bus(bus4.slave));
    mux_scan_n #(.W(4), .N(3), .SW(2), .DIV(4)) dut3 (.clk(clk), .clr(clr_tb), .bus(bus3.slave));
    mux_scan_n #(.W(4), .N(4), .SW(2), .DIV(1)) dut1 (.clk(clk), .clr(clr_tb), .bus(bus1.slave));

    // Behavioural model state, one entry per build.
    int NN [3] = '{4, 3, 4};
    int DD [3] = '{4, 4, 1};
    int m_ch [3];
    int m_z  [3];
    int m_tk [3];
    int m_cnt[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int slice(input int ch);
        return int'((d_tb >> (ch * 4)) & 16'hF);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (clr_tb) begin
                m_ch[k] = 0; m_z[k] = 0; m_tk[k] = 0; m_cnt[k] = 0;
            end else if (!en_tb) begin
                m_tk[k] = 0;
            end else if (mode_tb == 1'b0) begin
                m_ch[k]  = (int'(sel_tb) < NN[k]) ? int'(sel_tb) : NN[k] - 1;
                m_cnt[k] = 0;
                m_tk[k]  = 0;
                m_z[k]   = slice(m_ch[k]);
            end else begin
                if (m_cnt[k] == DD[k] - 1) begin
                    m_cnt[k] = 0;
                    m_ch[k]  = (m_ch[k] + 1) % NN[k];
                    m_tk[k]  = 1;
                end else begin
                    m_cnt[k]++;
                    m_tk[k] = 0;
                end
                m_z[k] = slice(m_ch[k]);
            end
        end
    endtask

    // One clock: model advances on the edge, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("n4d4.z",    32'(bus4.z),    32'(m_z[0]));
        check("n4d4.ch",   32'(bus4.ch),   32'(m_ch[0]));
        check("n4d4.tick", 32'(bus4.tick), 32'(m_tk[0]));
        check("n3d4.z",    32'(bus3.z),    32'(m_z[1]));
        check("n3d4.ch",   32'(bus3.ch),   32'(m_ch[1]));
        check("n3d4.tick", 32'(bus3.tick), 32'(m_tk[1]));
        check("n4d1.z",    32'(bus1.z),    32'(m_z[2]));
        check("n4d1.ch",   32'(bus1.ch),   32'(m_ch[2]));
        check("n4d1.tick", 32'(bus1.tick), 32'(m_tk[2]));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_ch[k] = 0; m_z[k] = 0; m_tk[k] = 0; m_cnt[k] = 0;
        end
        clr_tb = 1'b1; mode_tb = 1'b1; en_tb = 1'b1; sel_tb = 2'd0; d_tb = 16'hDCBA;
        #1;

        // Reset held two cycles in auto mode.
        cyc(); cyc();
        check("rst.z", 32'(bus4.z), 32'h0);
        check("rst.ch", 32'(bus4.ch), 32'h0);
        check("rst.tick", 32'(bus4.tick), 32'h0);
        clr_tb = 1'b0;
        cyc();
        check("rel.z", 32'(bus4.z), 32'hA);
        check("rel.ch", 32'(bus4.ch), 32'h0);

        // Manual selection and live data refresh.
        mode_tb = 1'b0; sel_tb = 2'd2;
        cyc();
        check("man.sel2.z", 32'(bus4.z), 32'hC);
        check("man.sel2.ch", 32'(bus4.ch), 32'h2);
        check("man.sel2.tick", 32'(bus4.tick), 32'h0);
        sel_tb = 2'd3;
        cyc();
        check("man.sel3.z", 32'(bus4.z), 32'hD);
        check("clamp.n3.ch", 32'(bus3.ch), 32'h2);
        check("clamp.n3.z", 32'(bus3.z), 32'hC);
        d_tb = 16'h5CBA;
        cyc();
        check("man.dchg.z", 32'(bus4.z), 32'h5);
        d_tb = 16'hDCBA; sel_tb = 2'd0;
        cyc();

        // Auto scan from ch0: advance every 4th edge.
        mode_tb = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            check("auto.tick", 32'(bus4.tick), (i % 4 == 0) ? 32'h1 : 32'h0);
            check("auto.ch", 32'(bus4.ch), 32'((i / 4) % 4));
            check("auto.z", 32'(bus4.z), 32'(10 + (i / 4) % 4));
        end

        // Enable gating at cnt=2.
        cyc(); cyc();
        en_tb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("gate.ch", 32'(bus4.ch), 32'h0);
            check("gate.tick", 32'(bus4.tick), 32'h0);
        end
        en_tb = 1'b1;
        cyc();
        check("gate.resume1.tick", 32'(bus4.tick), 32'h0);
        cyc();
        check("gate.resume2.tick", 32'(bus4.tick), 32'h1);
        check("gate.resume2.ch", 32'(bus4.ch), 32'h1);

        // Auto -> manual with an advance pending: discarded, no tick.
        cyc(); cyc(); cyc();
        mode_tb = 1'b0; sel_tb = 2'd0;
        cyc();
        check("switch.ch", 32'(bus4.ch), 32'h0);
        check("switch.z", 32'(bus4.z), 32'hA);
        check("switch.tick", 32'(bus4.tick), 32'h0);

        // DIV=1: advance and tick every enabled cycle, then reset mid-run.
        mode_tb = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check("div1.tick", 32'(bus1.tick), 32'h1);
            check("div1.ch", 32'(bus1.ch), 32'(i % 4));
        end
        clr_tb = 1'b1;
        cyc();
        check("div1.clr.ch", 32'(bus1.ch), 32'h0);
        check("div1.clr.tick", 32'(bus1.tick), 32'h0);
        clr_tb = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            d_tb    = 16'($urandom);
            sel_tb  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) mode_tb = ~mode_tb;
            en_tb   = ($urandom_range(0, 9) < 8);
            clr_tb  = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
